video_capture_mc: RTL and testbench

VIDEO_CAPTURE_MC -- requirements
Module: video_capture_mc

---
 rtl/video_capture_pkg.sv | 22 ++
 rtl/pixel_packer.sv | 69 ++++++
 rtl/video_capture_mc.sv | 237 +++++++++++++++++++++++
 tb/tb_video_capture_mc.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_capture_pkg.sv
// rtl/video_capture_pkg.sv - sync codes and FSM state type for the video capture block
//
// Purpose: shared definitions for video_capture_mc.
//   SYNC_* : 4-bit sync codes sampled alongside the pixel lanes
//   state_t: capture FSM states
package video_capture_pkg;

  localparam logic [3:0] SYNC_BLANK = 4'd0;
  localparam logic [3:0] SYNC_FS    = 4'd1;
  localparam logic [3:0] SYNC_LS    = 4'd2;
  localparam logic [3:0] SYNC_IMG   = 4'd3;
  localparam logic [3:0] SYNC_LE    = 4'd4;
  localparam logic [3:0] SYNC_FE    = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_FS,
    ST_FRAME,
    ST_LINE
  } state_t;

endpackage

// File: rtl/pixel_packer.sv
// rtl/pixel_packer.sv - packs consecutive pixel beats into one output word
//
// Purpose: gathers BEATS beats of BEAT_W bits into a word, first beat in the
// lowest bits, and presents the finished word one cycle after its last beat.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_beat_valid     : i_beat is to be packed this cycle
//   i_beat           : one beat of lane data
//   i_flush          : discard any partially filled word (wins over i_beat_valid)
//   o_word_done      : combinational, this cycle's beat completes a word
//   o_partial        : a partially filled word is held
//   o_word, o_valid  : registered finished word and its one-cycle strobe
module pixel_packer #(
  parameter int BEAT_W = 16,
  parameter int BEATS  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_beat_valid,
  input  logic [BEAT_W-1:0]        i_beat,
  input  logic                     i_flush,
  output logic                     o_word_done,
  output logic                     o_partial,
  output logic [BEAT_W*BEATS-1:0]  o_word,
  output logic                     o_valid
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]        r_cnt;
  logic [BEAT_W*BEATS-1:0] r_acc;
  logic [BEAT_W*BEATS-1:0] r_word;
  logic                    r_valid;
  logic [BEAT_W*BEATS-1:0] w_acc_next;
  logic                    w_take;

  always_comb begin
    w_take     = i_beat_valid && !i_flush;
    w_acc_next = r_acc;
    w_acc_next[int'(r_cnt)*BEAT_W +: BEAT_W] = i_beat;
  end

  assign o_word_done = w_take && (r_cnt == LAST_BEAT);
  assign o_partial   = (r_cnt != '0);
  assign o_word      = r_word;
  assign o_valid     = r_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= o_word_done;
      if (i_flush) begin
        r_cnt <= '0;
      end else if (w_take) begin
        r_acc <= w_acc_next;
        r_cnt <= o_word_done ? '0 : r_cnt + CNT_W'(1);
      end
      if (o_word_done) begin
        r_word <= w_acc_next;
      end
    end
  end

endmodule

// File: rtl/video_capture_mc.sv
// rtl/video_capture_mc.sv - multi-lane video capture into ping-pong frame buffers
//
// Purpose: follows FS/LS/IMG/LE/FE sync codes, packs IMG beats into OUT_W words
// and writes them to line/word addressed frame buffer memory, flagging any
// line or frame whose length differs from LINE_WORDS x LINES.
// Ports:
//   pclock, reset        : only clock (rising edge), asynchronous active-low reset
//   sync, data           : sync code and lane pixels (lane 0 in lowest bits)
//   enable               : arm capture; falling mid-frame lets the frame finish
//   err_clr              : clear line_len_err (a same-cycle error wins)
//   w_addr, w_data, we   : write port, we is a one-cycle strobe
//   buf_sel              : buffer currently being written
//   frame_done, frame_cnt: end-of-frame pulse and completed-frame counter
//   line_len_err, busy   : sticky length error, FSM not idle
module video_capture_mc
  import video_capture_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DATA_W     = 4,
  parameter int OUT_W      = 64,
  parameter int LINE_WORDS = 32,
  parameter int LINES      = 1080,
  parameter int ADDR_W     = 19,
  parameter int DOUBLE_BUF = 1
) (
  input  logic                   pclock,
  input  logic                   reset,
  input  logic [3:0]             sync,
  input  logic [N_CH*DATA_W-1:0] data,
  input  logic                   enable,
  input  logic                   err_clr,
  output logic [ADDR_W-1:0]      w_addr,
  output logic [OUT_W-1:0]       w_data,
  output logic                   we,
  output logic                   buf_sel,
  output logic                   frame_done,
  output logic [15:0]            frame_cnt,
  output logic                   line_len_err,
  output logic                   busy
);

  localparam int BEAT_W = N_CH * DATA_W;
  localparam int BEATS  = OUT_W / BEAT_W;
  localparam int LIDX_W = $clog2(LINES + 1);
  localparam int WIDX_W = $clog2(LINE_WORDS + 1);
  localparam logic [LIDX_W-1:0] LINES_C = LIDX_W'(LINES);
  localparam logic [WIDX_W-1:0] WORDS_C = WIDX_W'(LINE_WORDS);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LIDX_W-1:0]  r_line_idx;
  logic [WIDX_W-1:0]  r_word_idx;
  logic               r_line_drop;
  logic [ADDR_W-1:0]  r_w_addr;
  logic               r_buf_sel;
  logic               r_frame_done;
  logic [15:0]        r_frame_cnt;
  logic               r_err;

  logic               w_beat_valid;
  logic               w_flush;
  logic               w_frame_start;
  logic               w_line_start;
  logic               w_line_end;
  logic               w_abort;
  logic               w_frame_end;
  logic               w_err_set;
  logic               w_word_done;
  logic               w_partial;
  logic [ADDR_W-1:0]  w_addr_next;

  pixel_packer #(
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS)
  ) u_packer (
    .i_clk        (pclock),
    .i_rst_n      (reset),
    .i_beat_valid (w_beat_valid),
    .i_beat       (data),
    .i_flush      (w_flush),
    .o_word_done  (w_word_done),
    .o_partial    (w_partial),
    .o_word       (w_data),
    .o_valid      (we)
  );

  always_ff @(posedge pclock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_beat_valid  = 1'b0;
    w_flush       = 1'b0;
    w_frame_start = 1'b0;
    w_line_start  = 1'b0;
    w_line_end    = 1'b0;
    w_abort       = 1'b0;
    w_frame_end   = 1'b0;
    w_err_set     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_flush = 1'b1;
        if (enable) begin
          w_state_nxt = ST_WAIT_FS;
        end
      end
      ST_WAIT_FS: begin
        w_flush = 1'b1;
        if (sync == SYNC_FS) begin
          w_frame_start = 1'b1;
          w_state_nxt   = ST_FRAME;
        end else if (!enable) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FRAME: begin
        w_flush = 1'b1;
        case (sync)
          SYNC_FS: begin
            w_abort   = 1'b1;
            w_err_set = 1'b1;
          end
          SYNC_LS: begin
            w_line_start = 1'b1;
            w_state_nxt  = ST_LINE;
            // a line beyond LINES is walked through but never written
            if (r_line_idx == LINES_C) begin
              w_err_set = 1'b1;
            end
          end
          SYNC_FE: begin
            w_frame_end = 1'b1;
            w_state_nxt = enable ? ST_WAIT_FS : ST_IDLE;
            if (r_line_idx != LINES_C) begin
              w_err_set = 1'b1;
            end
          end
          default: ;
        endcase
      end
      ST_LINE: begin
        case (sync)
          SYNC_IMG: begin
            if (!r_line_drop) begin
              // once the line is full, surplus beats never reach the packer
              if (r_word_idx == WORDS_C) begin
                w_err_set = 1'b1;
              end else begin
                w_beat_valid = 1'b1;
              end
            end
          end
          SYNC_LE: begin
            w_flush     = 1'b1;
            w_state_nxt = ST_FRAME;
            if (!r_line_drop) begin
              w_line_end = 1'b1;
              if (w_partial || (r_word_idx != WORDS_C)) begin
                w_err_set = 1'b1;
              end
            end
          end
          SYNC_FS: begin
            w_flush     = 1'b1;
            w_abort     = 1'b1;
            w_err_set   = 1'b1;
            w_state_nxt = ST_FRAME;
          end
          default: ;
        endcase
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_addr_next = ADDR_W'(32'(r_buf_sel) * 32'(LINES * LINE_WORDS)
                              + 32'(r_line_idx) * 32'(LINE_WORDS)
                              + 32'(r_word_idx));

  always_ff @(posedge pclock or negedge reset) begin
    if (!reset) begin
      r_line_idx   <= '0;
      r_word_idx   <= '0;
      r_line_drop  <= 1'b0;
      r_w_addr     <= '0;
      r_buf_sel    <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_frame_start || w_abort || w_frame_end) begin
        r_line_idx <= '0;
      end else if (w_line_end) begin
        r_line_idx <= r_line_idx + LIDX_W'(1);
      end

      if (w_line_start) begin
        r_word_idx  <= '0;
        r_line_drop <= (r_line_idx == LINES_C);
      end else if (w_word_done) begin
        r_word_idx <= r_word_idx + WIDX_W'(1);
      end

      // address is captured alongside the word so both appear with we
      if (w_word_done) begin
        r_w_addr <= w_addr_next;
      end

      r_frame_done <= w_frame_end;
      if (w_frame_end) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
        if (DOUBLE_BUF != 0) begin
          r_buf_sel <= ~r_buf_sel;
        end
      end

      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign w_addr       = r_w_addr;
  assign buf_sel      = r_buf_sel;
  assign frame_done   = r_frame_done;
  assign frame_cnt    = r_frame_cnt;
  assign line_len_err = r_err;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_video_capture_mc.sv
// tb/tb_video_capture_mc.sv - directed self-checking bench for video_capture_mc
module tb_video_capture_mc;
  import video_capture_pkg::*;

  localparam int N_CH       = 2;
  localparam int DATA_W     = 4;
  localparam int OUT_W      = 32;
  localparam int LINE_WORDS = 4;
  localparam int LINES      = 6;
  localparam int ADDR_W     = 8;
  localparam int DOUBLE_BUF = 1;

  logic              pclock = 1'b0;
  logic              reset = 1'b0;
  logic [3:0]        sync = 4'd0;
  logic [7:0]        data = 8'd0;
  logic              enable = 1'b0;
  logic              err_clr = 1'b0;
  logic [ADDR_W-1:0] w_addr;
  logic [OUT_W-1:0]  w_data;
  logic              we;
  logic              buf_sel;
  logic              frame_done;
  logic [15:0]       frame_cnt;
  logic              line_len_err;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  logic [7:0]  q_addr[$];
  logic [31:0] q_data[$];

  video_capture_mc #(
    .N_CH(N_CH), .DATA_W(DATA_W), .OUT_W(OUT_W), .LINE_WORDS(LINE_WORDS),
    .LINES(LINES), .ADDR_W(ADDR_W), .DOUBLE_BUF(DOUBLE_BUF)
  ) dut (
    .pclock(pclock), .reset(reset), .sync(sync), .data(data),
    .enable(enable), .err_clr(err_clr), .w_addr(w_addr), .w_data(w_data),
    .we(we), .buf_sel(buf_sel), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .line_len_err(line_len_err), .busy(busy)
  );

  always #5 pclock = ~pclock;

  always @(negedge pclock) begin
    if (we) begin
      q_addr.push_back(w_addr);
      q_data.push_back(w_data);
    end
    if (frame_done) n_done++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] s, input logic [7:0] d);
    sync = s;
    data = d;
    @(posedge pclock);
    #1;
  endtask

  task automatic send_line(input int nbeats, input bit inc);
    drive(SYNC_LS, 8'h00);
    for (int i = 0; i < nbeats; i++)
      drive(SYNC_IMG, inc ? 8'(i + 1) : ((i % 2) != 0 ? 8'h34 : 8'h12));
    drive(SYNC_LE, 8'h00);
  endtask

  task automatic send_lines(input int n);
    for (int i = 0; i < n; i++) send_line(16, 1'b0);
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    drive(SYNC_BLANK, 8'h00);
    err_clr = 1'b0;
  endtask

  // consecutive addresses base.. starting at log entry idx; data checked when chk_data
  task automatic check_run(input string tag, input int idx, input int n, input int base, input bit chk_data);
    for (int k = 0; k < n && (idx + k) < q_addr.size(); k++) begin
      check_eq({tag, "_addr"}, q_addr[idx + k], base + k);
      if (chk_data) check_eq({tag, "_data"}, q_data[idx + k], 32'h34123412);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_we"}, we, 0);
    check_eq({tag, "_done"}, frame_done, 0);
    check_eq({tag, "_buf"}, buf_sel, 0);
    check_eq({tag, "_err"}, line_len_err, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_addr"}, w_addr, 0);
    check_eq({tag, "_data"}, w_data, 0);
    check_eq({tag, "_cnt"}, frame_cnt, 0);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge pclock);
    #1;
    check_zero("rst");
    reset = 1'b1;
    enable = 1'b1;
    drive(SYNC_BLANK, 8'h00);
    check_eq("busy_on", busy, 1);

    // frame A: buffer 0, first-word latency checked beat by beat
    clear_log();
    drive(SYNC_FS, 8'h00);
    drive(SYNC_LS, 8'h00);
    drive(SYNC_IMG, 8'h12);
    drive(SYNC_IMG, 8'h34);
    drive(SYNC_IMG, 8'h12);
    check_eq("lat_pre_we", we, 0);
    drive(SYNC_IMG, 8'h34);
    check_eq("lat_we", we, 1);
    check_eq("lat_addr", w_addr, 0);
    check_eq("lat_data", w_data, 32'h34123412);
    drive(SYNC_IMG, 8'h12);
    check_eq("lat_post_we", we, 0);
    for (int i = 5; i < 16; i++) drive(SYNC_IMG, (i % 2) != 0 ? 8'h34 : 8'h12);
    drive(SYNC_LE, 8'h00);
    send_lines(5);
    drive(SYNC_FE, 8'h00);
    check_eq("a_done_pulse", frame_done, 1);
    drive(SYNC_BLANK, 8'h00);
    check_eq("a_done_low", frame_done, 0);
    check_eq("a_nwr", q_addr.size(), 24);
    check_run("a", 0, 24, 0, 1'b1);
    check_eq("a_ndone", n_done, 1);
    check_eq("a_cnt", frame_cnt, 1);
    check_eq("a_buf", buf_sel, 1);
    check_eq("a_err", line_len_err, 0);

    // frame B: buffer 1, first line carries lane-order pattern 01..10
    clear_log();
    drive(SYNC_FS, 8'h00);
    send_line(16, 1'b1);
    send_lines(5);
    drive(SYNC_FE, 8'h00);
    drive(SYNC_BLANK, 8'h00);
    check_eq("b_nwr", q_addr.size(), 24);
    check_run("b", 0, 24, 24, 1'b0);
    if (q_data.size() >= 5) begin
      check_eq("b_w0", q_data[0], 32'h04030201);
      check_eq("b_w1", q_data[1], 32'h08070605);
      check_eq("b_w2", q_data[2], 32'h0C0B0A09);
      check_eq("b_w3", q_data[3], 32'h100F0E0D);
      check_eq("b_w4", q_data[4], 32'h34123412);
    end
    check_eq("b_ndone", n_done, 2);
    check_eq("b_cnt", frame_cnt, 2);
    check_eq("b_buf", buf_sel, 0);

    // frame C: over-long first line, err_clr colliding with the error
    clear_log();
    drive(SYNC_FS, 8'h00);
    drive(SYNC_LS, 8'h00);
    for (int i = 0; i < 16; i++) drive(SYNC_IMG, (i % 2) != 0 ? 8'h34 : 8'h12);
    check_eq("c_err_before", line_len_err, 0);
    err_clr = 1'b1;
    drive(SYNC_IMG, 8'h12);
    err_clr = 1'b0;
    check_eq("c_set_wins", line_len_err, 1);
    drive(SYNC_IMG, 8'h34);
    drive(SYNC_LE, 8'h00);
    check_eq("c_err_sticky", line_len_err, 1);
    pulse_clr();
    check_eq("c_err_clr", line_len_err, 0);
    send_lines(5);
    drive(SYNC_FE, 8'h00);
    drive(SYNC_BLANK, 8'h00);
    check_eq("c_nwr", q_addr.size(), 24);
    check_run("c", 0, 24, 0, 1'b1);
    check_eq("c_err_end", line_len_err, 0);
    check_eq("c_cnt", frame_cnt, 3);
    check_eq("c_buf", buf_sel, 1);

    // frame D: FS after two lines aborts and restarts at buffer offset
    clear_log();
    drive(SYNC_FS, 8'h00);
    send_lines(2);
    drive(SYNC_FS, 8'h00);
    drive(SYNC_BLANK, 8'h00);
    check_eq("d_abort_err", line_len_err, 1);
    check_eq("d_abort_cnt", frame_cnt, 3);
    check_eq("d_abort_buf", buf_sel, 1);
    check_eq("d_abort_ndone", n_done, 3);
    send_lines(6);
    drive(SYNC_FE, 8'h00);
    drive(SYNC_BLANK, 8'h00);
    check_eq("d_nwr", q_addr.size(), 32);
    check_run("d_pre", 0, 8, 24, 1'b1);
    check_run("d_post", 8, 24, 24, 1'b1);
    check_eq("d_cnt", frame_cnt, 4);
    check_eq("d_buf", buf_sel, 0);
    check_eq("d_ndone", n_done, 4);

    // frame E: short line with partial word, enable dropped mid-frame
    pulse_clr();
    check_eq("e_err_clr", line_len_err, 0);
    clear_log();
    drive(SYNC_FS, 8'h00);
    send_line(10, 1'b0);
    check_eq("e_short_err", line_len_err, 1);
    pulse_clr();
    drive(SYNC_LS, 8'h00);
    for (int i = 0; i < 8; i++) drive(SYNC_IMG, (i % 2) != 0 ? 8'h34 : 8'h12);
    enable = 1'b0;
    for (int i = 8; i < 16; i++) drive(SYNC_IMG, (i % 2) != 0 ? 8'h34 : 8'h12);
    drive(SYNC_LE, 8'h00);
    send_lines(4);
    check_eq("e_busy_mid", busy, 1);
    drive(SYNC_FE, 8'h00);
    drive(SYNC_BLANK, 8'h00);
    check_eq("e_nwr", q_addr.size(), 22);
    check_run("e_short", 0, 2, 0, 1'b1);
    check_run("e_rest", 2, 20, 4, 1'b1);
    check_eq("e_err_end", line_len_err, 0);
    check_eq("e_cnt", frame_cnt, 5);
    check_eq("e_buf", buf_sel, 1);
    check_eq("e_idle", busy, 0);

    // frame F: seventh line exceeds LINES and is dropped
    enable = 1'b1;
    drive(SYNC_BLANK, 8'h00);
    clear_log();
    drive(SYNC_FS, 8'h00);
    send_lines(6);
    check_eq("f_err_ok", line_len_err, 0);
    send_lines(1);
    check_eq("f_err_extra", line_len_err, 1);
    drive(SYNC_FE, 8'h00);
    drive(SYNC_BLANK, 8'h00);
    check_eq("f_nwr", q_addr.size(), 24);
    check_run("f", 0, 24, 24, 1'b1);
    check_eq("f_cnt", frame_cnt, 6);
    check_eq("f_buf", buf_sel, 0);

    // frame G: reset during line 5, input discarded until the next FS
    pulse_clr();
    clear_log();
    drive(SYNC_FS, 8'h00);
    send_lines(4);
    drive(SYNC_LS, 8'h00);
    for (int i = 0; i < 6; i++) drive(SYNC_IMG, (i % 2) != 0 ? 8'h34 : 8'h12);
    check_eq("g_pre_nwr", q_addr.size(), 17);
    reset = 1'b0;
    #1;
    check_zero("g_rst");
    @(posedge pclock);
    #1;
    reset = 1'b1;
    clear_log();
    for (int i = 0; i < 8; i++) drive(SYNC_IMG, 8'h12);
    drive(SYNC_LE, 8'h00);
    send_line(8, 1'b0);
    check_eq("g_discard_nwr", q_addr.size(), 0);
    drive(SYNC_FS, 8'h00);
    send_lines(2);
    drive(SYNC_FE, 8'h00);
    drive(SYNC_BLANK, 8'h00);
    check_eq("g_nwr", q_addr.size(), 8);
    check_run("g", 0, 8, 0, 1'b1);
    check_eq("g_cnt", frame_cnt, 1);
    check_eq("g_short_err", line_len_err, 1);
    check_eq("g_buf", buf_sel, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
